edge_detect_multi: RTL and testbench
====================================

Name: edge_detect_multi

Overview:
- Multi-channel, parametrised edge detector for asynchronous or noisy single-bit inputs such as buttons, external strobes and handshake lines.
- Each channel provides:
  - a configurable synchroniser chain;
  - an optional debounce filter;
  - a per-channel edge mode: rise, fall, both or off;
  - a one-cycle event pulse plus a sticky pending flag with software clear.
- Sits between raw pins and the control FSMs; replaces ad-hoc single-channel rising-edge detectors.

Parameters:
- NCH, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel (legal range 2..4).
- DEBOUNCE_CYC, 0, consecutive differing samples needed to accept a level change. 0 and 1 both mean no filtering.
- RESET_LEVEL, 0, reset value of the synchroniser flops and the filtered level.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  NCH  raw asynchronous inputs, bit i = channel i.
- mode  in  2*NCH  per-channel edge mode; bits [2i+1:2i] belong to channel i. 00 = off, 01 = rise, 10 = fall, 11 = both.
- clr  in  NCH  per-channel pending clear, level-sensitive, synchronous.
- pulse  out  NCH  one-cycle event strobe per channel.
- pending  out  NCH  sticky event flag per channel.
- level  out  NCH  filtered (debounced) level per channel.
- any_pending  out  1  OR-reduction of pending.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - sync flops = RESET_LEVEL, level = RESET_LEVEL;
  - debounce counter = 0, pulse = 0, pending = 0, any_pending = 0.
- Synchroniser: shift register of SYNC_STAGES flops per channel; s_out is the last stage. No logic between stages.
- Debounce, with D = max(DEBOUNCE_CYC, 1) and counter width max(1, $clog2(D+1)):
  - s_out == level at an edge: counter <= 0.
  - s_out != level and counter == D-1: level <= s_out, counter <= 0 (accepted change).
  - otherwise: counter <= counter + 1.
  - A glitch shorter than D samples never changes level. The counter never exceeds D-1, so no wrap.
- Edge classification happens at the same edge that updates level:
  - rising change: level 0->1; falling change: level 1->0.
  - pulse[i] <= 1 for exactly one cycle if the change matches mode[i]; otherwise 0.
  - mode is sampled only at the change edge. Changing mode never itself generates a pulse.
- Latency:
  - data_in is first sampled high/low at edge 0 and held stable.
  - level and pulse update at edge SYNC_STAGES + D - 1 and are visible in the following cycle.
  - Example: SYNC_STAGES = 2, D = 1 gives update at edge 2.
- Back-to-back changes: the minimum spacing between pulses on one channel is D cycles. Each accepted change produces its own pulse.
- Pending:
  - pending[i] <= (pending[i] & ~clr[i]) | pulse_next[i].
  - If set and clear coincide in the same cycle, set wins, so no event is lost.
  - pending stays set until cleared.
- any_pending is the combinational OR of the pending register bits; no extra latency.
- Reset mid-operation: all state is cleared immediately, including any pulse in flight. After release, if the input differs from RESET_LEVEL, the channel reports a normal edge after the full latency.
- Channels are fully independent and never share counters.

Decomposition:
- Package edge_pkg:
  - mode encodings: MODE_OFF = 2'b00, MODE_RISE = 2'b01, MODE_FALL = 2'b10, MODE_BOTH = 2'b11;
  - edge_mode_t typedef (2 bits).
- One natural sub-module, edge_chan:
  - one channel containing synchroniser, debounce counter, edge classify and pending;
  - parameters SYNC_STAGES, DEBOUNCE_CYC, RESET_LEVEL.
- Top instantiates NCH copies in a generate loop and ORs pending into any_pending.

Test Plan:
- Basic rise, NCH = 4, SYNC_STAGES = 2, DEBOUNCE_CYC = 0, mode = all 01:
  - stimulus: data_in[0] 0->1 before edge 0;
  - required: pulse[0] high for exactly the cycle after edge 2; pending[0] = 1 and any_pending = 1 from then on; other channels stay 0.
- Both-edges mode, mode[3:2] = 11, data_in[1] = 1 for 10 cycles then 0:
  - required: two single-cycle pulses on pulse[1], 10 cycles apart; level[1] follows the input with 2-cycle latency.
- Debounce, DEBOUNCE_CYC = 4, mode[1:0] = 01:
  - 3-cycle high glitch on ch0 -> no pulse, level[0] stays 0, counter returns to 0.
  - Then a sustained high -> pulse[0] after edge 5.
- Set/clear collision:
  - hold clr[2] = 1 on the same cycle pulse[2] fires -> pending[2] = 1.
  - clr[2] = 1 one cycle later -> pending[2] = 0 and any_pending = 0.
- Mode off and mode change:
  - mode[5:4] = 00 with input toggling -> no pulse, but level tracks the input.
  - Switch mode to 01 while level[2] = 1 -> no pulse until the next accepted rising change.
- Async reset mid-debounce, DEBOUNCE_CYC = 4:
  - assert rst with the counter at 2 -> pulse, pending and level go to 0 immediately, without waiting for a clk edge.
  - Release with input held at 1 -> one rising pulse after the full latency (edge 5).

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
//   edge_mode_t : per-channel edge selection (off / rise / fall / both)
//   deb_len     : effective debounce length (0 and 1 both mean "no filtering")
//   cnt_width   : width of the debounce counter for a given effective length
package edge_pkg;

  typedef logic [1:0] edge_mode_t;

  localparam edge_mode_t MODE_OFF  = 2'b00;
  localparam edge_mode_t MODE_RISE = 2'b01;
  localparam edge_mode_t MODE_FALL = 2'b10;
  localparam edge_mode_t MODE_BOTH = 2'b11;

  function automatic int unsigned deb_len(input int unsigned cyc);
    return (cyc < 1) ? 1 : cyc;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned d);
    return ($clog2(d + 1) < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: synchroniser, debounce filter, edge classify, sticky pending.
// Ports:
//   clk, rst   : clock, async active-high reset
//   data_i     : raw asynchronous input
//   mode_i     : edge selection, sampled only when a level change is accepted
//   clr_i      : level-sensitive pending clear (a coincident set wins)
//   pulse_o    : one-cycle event strobe
//   pending_o  : sticky event flag
//   level_o    : filtered level
module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 0,
  parameter bit          RESET_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_i,
  input  edge_mode_t mode_i,
  input  logic       clr_i,
  output logic       pulse_o,
  output logic       pending_o,
  output logic       level_o
);

  localparam int unsigned D  = deb_len(DEBOUNCE_CYC);
  localparam int unsigned CW = cnt_width(D);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   pending_q, pending_d;
  logic                   s_out;

  assign s_out = sync_q[SYNC_STAGES-1];

  // Next-state: shift synchroniser, run debounce counter, classify accepted changes.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], data_i};
    cnt_d     = cnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;

    if (s_out == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(D - 1)) begin
      // D consecutive differing samples: accept the new level.
      level_d = s_out;
      cnt_d   = '0;
      if (s_out) pulse_d = (mode_i == MODE_RISE) || (mode_i == MODE_BOTH);
      else       pulse_d = (mode_i == MODE_FALL) || (mode_i == MODE_BOTH);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    pending_d = (pending_q & ~clr_i) | pulse_d;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q     <= '0;
      level_q   <= RESET_LEVEL;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign pending_o = pending_q;
  assign level_o   = level_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector for asynchronous / noisy single-bit inputs.
// Ports:
//   clk, rst     : clock, async active-high reset
//   data_in      : raw inputs, bit i = channel i
//   mode         : per-channel edge mode, bits [2i+1:2i] = channel i
//   clr          : per-channel pending clear
//   pulse        : one-cycle event strobes
//   pending      : sticky event flags
//   level        : filtered levels
//   any_pending  : OR of pending (no added latency)
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 0,
  parameter bit          RESET_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   data_in,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   pulse,
  output logic [NCH-1:0]   pending,
  output logic [NCH-1:0]   level,
  output logic             any_pending
);

  // Independent channel instances.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .data_i   (data_in[i]),
      .mode_i   (edge_mode_t'(mode[2*i +: 2])),
      .clr_i    (clr[i]),
      .pulse_o  (pulse[i]),
      .pending_o(pending[i]),
      .level_o  (level[i])
    );
  end

  assign any_pending = |pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: two instances (no filtering and DEBOUNCE_CYC=4) share
// the same stimulus; a sample-history reference model predicts both.
module tb_edge_detect_multi;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int HN   = 64;
  localparam bit RL   = 1'b0;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] data_in;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0] clr;

  logic [NCH-1:0] pulse0, pending0, level0;
  logic           anyp0;
  logic [NCH-1:0] pulse4, pending4, level4;
  logic           anyp4;

  edge_detect_multi #(.NCH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(0), .RESET_LEVEL(RL)) u_d0 (
    .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .clr(clr),
    .pulse(pulse0), .pending(pending0), .level(level0), .any_pending(anyp0)
  );

  edge_detect_multi #(.NCH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(4), .RESET_LEVEL(RL)) u_d4 (
    .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .clr(clr),
    .pulse(pulse4), .pending(pending4), .level(level4), .any_pending(anyp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: hist holds the value each channel's first sync stage captured at each
  // edge. A change is accepted when the last D synchronised samples all differ from the level.
  bit hist [NCH][HN];
  bit mlvl [2][NCH];
  bit mpls [2][NCH];
  bit mpend[2][NCH];
  int dval [2] = '{1, 4};
  int cyc = 1000;

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      for (int h = 0; h < HN; h++) hist[ch][h] = RL;
      for (int dd = 0; dd < 2; dd++) begin
        mlvl[dd][ch]  = RL;
        mpls[dd][ch]  = 1'b0;
        mpend[dd][ch] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    bit          acc;
    logic [1:0]  m;
    cyc++;
    for (int ch = 0; ch < NCH; ch++) hist[ch][cyc % HN] = rst ? RL : data_in[ch];
    for (int dd = 0; dd < 2; dd++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (rst) begin
          mlvl[dd][ch]  = RL;
          mpls[dd][ch]  = 1'b0;
          mpend[dd][ch] = 1'b0;
        end else begin
          acc = 1'b1;
          for (int k = 0; k < dval[dd]; k++)
            if (hist[ch][(cyc - SYNC - k) % HN] == mlvl[dd][ch]) acc = 1'b0;
          mpls[dd][ch] = 1'b0;
          if (acc) begin
            mlvl[dd][ch] = ~mlvl[dd][ch];
            m = mode[2*ch +: 2];
            mpls[dd][ch] = mlvl[dd][ch] ? m[0] : m[1];
          end
          mpend[dd][ch] = (mpend[dd][ch] & ~clr[ch]) | mpls[dd][ch];
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] ep [2];
    logic [NCH-1:0] en [2];
    logic [NCH-1:0] el [2];
    for (int dd = 0; dd < 2; dd++)
      for (int ch = 0; ch < NCH; ch++) begin
        ep[dd][ch] = mpls[dd][ch];
        en[dd][ch] = mpend[dd][ch];
        el[dd][ch] = mlvl[dd][ch];
      end
    check("d0_pulse",   32'(pulse0),   32'(ep[0]));
    check("d0_pending", 32'(pending0), 32'(en[0]));
    check("d0_level",   32'(level0),   32'(el[0]));
    check("d0_anyp",    32'(anyp0),    32'(|en[0]));
    check("d4_pulse",   32'(pulse4),   32'(ep[1]));
    check("d4_pending", 32'(pending4), 32'(en[1]));
    check("d4_level",   32'(level4),   32'(el[1]));
    check("d4_anyp",    32'(anyp4),    32'(|en[1]));
  endtask

  // One clock: model the edge, sample 1ns later, return at the falling edge to drive.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n, t1, t2, tp;
    rst     = 1'b1;
    data_in = '0;
    mode    = '0;
    clr     = '0;
    model_reset();
    #1;
    check("rst_pulse",   32'(pulse0),   32'(0));
    check("rst_pending", 32'(pending0), 32'(0));
    check("rst_level",   32'(level4),   32'(0));
    check("rst_anyp",    32'(anyp4),    32'(0));
    do_reset();

    // Basic rise on ch0, all channels in rise mode.
    mode    = 8'h55;
    data_in = 4'b0001;
    step();
    step();
    check("rise_e1_pulse", 32'(pulse0), 32'(0));
    step();
    check("rise_e2_pulse", 32'(pulse0), 32'(4'b0001));
    step();
    check("rise_after_pulse", 32'(pulse0),   32'(0));
    check("rise_pending",     32'(pending0), 32'(4'b0001));
    check("rise_anyp",        32'(anyp0),    32'(1));

    // Both-edges mode on ch1: 10 cycles high then low.
    mode = 8'h5D;
    n = 0; t1 = -1; t2 = -1;
    data_in[1] = 1'b1;
    for (int s = 0; s < 20; s++) begin
      if (s == 10) data_in[1] = 1'b0;
      step();
      if (pulse0[1]) begin
        n++;
        if (n == 1) t1 = s; else t2 = s;
      end
    end
    check("both_count", 32'(n), 32'(2));
    check("both_gap",   32'(t2 - t1), 32'(10));

    // Debounce (DEBOUNCE_CYC=4) on ch0: settle low, 3-cycle glitch, then sustained high.
    mode = 8'h55;
    data_in[0] = 1'b0;
    for (int s = 0; s < 12; s++) step();
    n = 0;
    data_in[0] = 1'b1;
    for (int s = 0; s < 14; s++) begin
      if (s == 3) data_in[0] = 1'b0;
      step();
      if (pulse4[0]) n++;
    end
    check("glitch_no_pulse", 32'(n), 32'(0));
    check("glitch_level",    32'(level4[0]), 32'(0));
    tp = -1;
    data_in[0] = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step();
      if (pulse4[0] && tp < 0) tp = s;
    end
    check("deb_latency", 32'(tp), 32'(5));

    // Set/clear collision on ch2.
    data_in = '0;
    for (int s = 0; s < 12; s++) step();
    clr = 4'hF;
    step();
    clr = '0;
    data_in[2] = 1'b1;
    step();
    step();
    clr[2] = 1'b1;
    step();
    check("coll_pulse",   32'(pulse0[2]),   32'(1));
    check("coll_pending", 32'(pending0[2]), 32'(1));
    clr = 4'hF;
    step();
    clr = '0;
    check("clr_pending", 32'(pending0), 32'(0));
    check("clr_anyp",    32'(anyp0),    32'(0));

    // Mode off on ch2: level tracks, no pulses; then rise mode with level already high.
    mode = 8'h45;
    n = 0;
    for (int s = 0; s < 24; s++) begin
      if (s % 6 == 0) data_in[2] = ~data_in[2];
      step();
      if (pulse0[2] || pulse4[2]) n++;
    end
    check("off_no_pulse", 32'(n), 32'(0));
    data_in[2] = 1'b1;
    for (int s = 0; s < 10; s++) step();
    check("off_level", 32'(level0[2]), 32'(1));
    mode = 8'h55;
    n = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (pulse0[2]) n++;
    end
    check("modechg_no_pulse", 32'(n), 32'(0));
    data_in[2] = 1'b0;
    for (int s = 0; s < 4; s++) step();
    data_in[2] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      if (pulse0[2]) n++;
    end
    check("modechg_rise", 32'(n), 32'(1));

    // Async reset in the middle of a debounce count.
    data_in = '0;
    do_reset();
    mode    = 8'h55;
    data_in = 4'b0001;
    for (int s = 0; s < 4; s++) step();
    check("arst_pre_pending", 32'(pending0), 32'(4'b0001));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_pulse4",   32'(pulse4),   32'(0));
    check("arst_pending0", 32'(pending0), 32'(0));
    check("arst_level0",   32'(level0),   32'(0));
    check("arst_anyp0",    32'(anyp0),    32'(0));
    step();
    rst = 1'b0;
    tp = -1;
    for (int s = 0; s < 9; s++) begin
      step();
      if (pulse4[0] && tp < 0) tp = s;
    end
    check("arst_relatency", 32'(tp), 32'(5));

    // Randomized traffic.
    for (int s = 0; s < 1500; s++) begin
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 5) == 0) data_in[ch] = ~data_in[ch];
      if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
      clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 199) == 0) begin
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
